// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-RAM sequencing controller.
package dmem_ctrl_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] DMEM_WORD = 2'b00;
   localparam logic [1:0] DMEM_HALF = 2'b01;
   localparam logic [1:0] DMEM_BYTE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR      = 3'd3,
      ST_DONE    = 3'd4
   } dmem_state_e;

   // Size code 2'b11 behaves as a halfword, so it shares the halfword rule.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         DMEM_WORD: mis = (addr_lo != 2'b00);
         DMEM_BYTE: mis = 1'b0;
         default:   mis = addr_lo[0];
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// store merge of a sub-word into the word read back from RAM.
module dmem_lane
   import dmem_ctrl_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] rd_word,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [1:0]            size,
   input  logic [1:0]            addr_lo,
   input  logic                  is_unsigned,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] merged_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        sext_s;

   // Lane selection, extension and merge.
   always_comb begin
      byte_s      = 8'h00;
      half_s      = 16'h0000;
      sext_s      = 1'b0;
      load_data   = rd_word;
      merged_word = rd_word;

      case (addr_lo)
         2'd0:    byte_s = rd_word[7:0];
         2'd1:    byte_s = rd_word[15:8];
         2'd2:    byte_s = rd_word[23:16];
         default: byte_s = rd_word[31:24];
      endcase

      if (addr_lo[1]) begin
         half_s = rd_word[31:16];
      end else begin
         half_s = rd_word[15:0];
      end

      case (size)
         DMEM_WORD: begin
            load_data   = rd_word;
            merged_word = wdata;
         end
         DMEM_BYTE: begin
            sext_s    = ~is_unsigned & byte_s[7];
            load_data = {{24{sext_s}}, byte_s};
            case (addr_lo)
               2'd0:    merged_word[7:0]   = wdata[7:0];
               2'd1:    merged_word[15:8]  = wdata[7:0];
               2'd2:    merged_word[23:16] = wdata[7:0];
               default: merged_word[31:24] = wdata[7:0];
            endcase
         end
         default: begin
            sext_s    = ~is_unsigned & half_s[15];
            load_data = {{16{sext_s}}, half_s};
            if (addr_lo[1]) begin
               merged_word[31:16] = wdata[15:0];
            end else begin
               merged_word[15:0] = wdata[15:0];
            end
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-RAM sequencing controller: arbitrates core and loader ports, runs
// read-modify-write for sub-word stores and returns extended sub-word loads.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_t,
   input  logic                  rst_t,
   input  logic                  core_req_t,
   input  logic                  core_we_t,
   input  logic [1:0]            core_size_t,
   input  logic                  core_unsigned_t,
   input  logic [31:0]           core_addr_t,
   input  logic [31:0]           core_wdata_t,
   output logic [31:0]           core_rdata_t,
   output logic                  core_ack_t,
   output logic                  core_misalign_t,
   input  logic                  ldr_req_t,
   input  logic                  ldr_we_t,
   input  logic [31:0]           ldr_addr_t,
   input  logic [31:0]           ldr_wdata_t,
   output logic [31:0]           ldr_rdata_t,
   output logic                  ldr_ack_t,
   output logic                  ram_en_t,
   output logic                  ram_we_t,
   output logic [ADDR_WIDTH-1:0] ram_addr_t,
   output logic [31:0]           ram_wdata_t,
   input  logic [31:0]           ram_rdata_t
);

   localparam int AW2 = ADDR_WIDTH + 2;

   dmem_state_e state_q, state_d;

   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [AW2-1:0]        addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  gnt_ldr_q, gnt_ldr_d;
   logic                  err_q, err_d;
   logic                  last_ldr_q, last_ldr_d;

   logic [31:0]           core_rdata_q, core_rdata_d;
   logic                  core_ack_q, core_ack_d;
   logic                  core_misalign_q, core_misalign_d;
   logic [31:0]           ldr_rdata_q, ldr_rdata_d;
   logic                  ldr_ack_q, ldr_ack_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]           ram_wdata_q, ram_wdata_d;

   logic                  req_any_s;
   logic                  pick_ldr_s;
   logic                  done_s;
   logic                  rd_done_s;
   logic [31:0]           load_data_s;
   logic [31:0]           merged_s;
   logic                  unused_s;

   // Address bits above the RAM range wrap; loader byte offset is ignored.
   assign unused_s = ^{core_addr_t[31:AW2], ldr_addr_t[31:AW2], ldr_addr_t[1:0]};

   dmem_lane u_lane (
      .rd_word     (ram_rdata_t),
      .wdata       (wdata_q),
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .is_unsigned (uns_q),
      .load_data   (load_data_s),
      .merged_word (merged_s)
   );

   // Round-robin grant and request capture; the lone requester always wins.
   always_comb begin
      req_any_s  = core_req_t | ldr_req_t;
      pick_ldr_s = ldr_req_t & (~core_req_t | ~last_ldr_q);
      if ((state_q == ST_IDLE) && req_any_s) begin
         if (pick_ldr_s) begin
            we_d       = ldr_we_t;
            size_d     = DMEM_WORD;
            uns_d      = 1'b0;
            addr_d     = {ldr_addr_t[AW2-1:2], 2'b00};
            wdata_d    = ldr_wdata_t;
            gnt_ldr_d  = 1'b1;
            err_d      = 1'b0;
            last_ldr_d = 1'b1;
         end else begin
            we_d       = core_we_t;
            size_d     = core_size_t;
            uns_d      = core_unsigned_t;
            addr_d     = core_addr_t[AW2-1:0];
            wdata_d    = core_wdata_t;
            gnt_ldr_d  = 1'b0;
            err_d      = is_misaligned(core_size_t, core_addr_t[1:0]);
            last_ldr_d = 1'b0;
         end
      end else begin
         we_d       = we_q;
         size_d     = size_q;
         uns_d      = uns_q;
         addr_d     = addr_q;
         wdata_d    = wdata_q;
         gnt_ldr_d  = gnt_ldr_q;
         err_d      = err_q;
         last_ldr_d = last_ldr_q;
      end
   end

   // Next-state logic.
   always_comb begin
      case (state_q)
         ST_IDLE: begin
            if (!req_any_s) begin
               state_d = ST_IDLE;
            end else if (err_d) begin
               state_d = ST_DONE;
            end else if (we_d && (size_d == DMEM_WORD)) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_RD: state_d = ST_RD_DATA;
         ST_RD_DATA: begin
            if (we_q) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_WR:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state.
   always_comb begin
      done_s    = (state_d == ST_DONE);
      rd_done_s = (state_q == ST_RD_DATA) && done_s;
      ram_en_d  = (state_d == ST_RD) || (state_d == ST_WR);
      ram_we_d  = (state_d == ST_WR);

      if (ram_en_d) begin
         ram_addr_d = addr_d[AW2-1:2];
      end else begin
         ram_addr_d = '0;
      end

      if (ram_we_d) begin
         if (state_q == ST_RD_DATA) begin
            ram_wdata_d = merged_s;
         end else begin
            ram_wdata_d = wdata_d;
         end
      end else begin
         ram_wdata_d = 32'h0000_0000;
      end

      core_ack_d      = done_s & ~gnt_ldr_d;
      ldr_ack_d       = done_s & gnt_ldr_d;
      core_misalign_d = done_s & ~gnt_ldr_d & err_d;

      if (rd_done_s && !gnt_ldr_q) begin
         core_rdata_d = load_data_s;
      end else begin
         core_rdata_d = 32'h0000_0000;
      end

      if (rd_done_s && gnt_ldr_q) begin
         ldr_rdata_d = ram_rdata_t;
      end else begin
         ldr_rdata_d = 32'h0000_0000;
      end
   end

   // State register.
   always_ff @(posedge clk_t) begin
      if (rst_t) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Captured request, arbitration pointer and registered outputs.
   always_ff @(posedge clk_t) begin
      if (rst_t) begin
         we_q            <= 1'b0;
         size_q          <= 2'b00;
         uns_q           <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= 32'h0000_0000;
         gnt_ldr_q       <= 1'b0;
         err_q           <= 1'b0;
         last_ldr_q      <= 1'b1;
         core_rdata_q    <= 32'h0000_0000;
         core_ack_q      <= 1'b0;
         core_misalign_q <= 1'b0;
         ldr_rdata_q     <= 32'h0000_0000;
         ldr_ack_q       <= 1'b0;
         ram_en_q        <= 1'b0;
         ram_we_q        <= 1'b0;
         ram_addr_q      <= '0;
         ram_wdata_q     <= 32'h0000_0000;
      end else begin
         we_q            <= we_d;
         size_q          <= size_d;
         uns_q           <= uns_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         gnt_ldr_q       <= gnt_ldr_d;
         err_q           <= err_d;
         last_ldr_q      <= last_ldr_d;
         core_rdata_q    <= core_rdata_d;
         core_ack_q      <= core_ack_d;
         core_misalign_q <= core_misalign_d;
         ldr_rdata_q     <= ldr_rdata_d;
         ldr_ack_q       <= ldr_ack_d;
         ram_en_q        <= ram_en_d;
         ram_we_q        <= ram_we_d;
         ram_addr_q      <= ram_addr_d;
         ram_wdata_q     <= ram_wdata_d;
      end
   end

   assign core_rdata_t    = core_rdata_q;
   assign core_ack_t      = core_ack_q;
   assign core_misalign_t = core_misalign_q;
   assign ldr_rdata_t     = ldr_rdata_q;
   assign ldr_ack_t       = ldr_ack_q;
   assign ram_en_t        = ram_en_q;
   assign ram_we_t        = ram_we_q;
   assign ram_addr_t      = ram_addr_q;
   assign ram_wdata_t     = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a word-array reference memory.
module tb_dmem_ctrl;

   localparam int AW = 10;

   logic          clk_t;
   logic          rst_t;
   logic          core_req_t, core_we_t, core_unsigned_t;
   logic [1:0]    core_size_t;
   logic [31:0]   core_addr_t, core_wdata_t, core_rdata_t;
   logic          core_ack_t, core_misalign_t;
   logic          ldr_req_t, ldr_we_t;
   logic [31:0]   ldr_addr_t, ldr_wdata_t, ldr_rdata_t;
   logic          ldr_ack_t;
   logic          ram_en_t, ram_we_t;
   logic [AW-1:0] ram_addr_t;
   logic [31:0]   ram_wdata_t, ram_rdata_t;

   logic [31:0]   mem [0:1023];
   logic [31:0]   ref_mem [0:1023];
   logic          poke_en;
   logic [AW-1:0] poke_addr;
   logic [31:0]   poke_data;

   int n_checks;
   int n_errors;

   dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk_t(clk_t), .rst_t(rst_t),
      .core_req_t(core_req_t), .core_we_t(core_we_t), .core_size_t(core_size_t),
      .core_unsigned_t(core_unsigned_t), .core_addr_t(core_addr_t),
      .core_wdata_t(core_wdata_t), .core_rdata_t(core_rdata_t),
      .core_ack_t(core_ack_t), .core_misalign_t(core_misalign_t),
      .ldr_req_t(ldr_req_t), .ldr_we_t(ldr_we_t), .ldr_addr_t(ldr_addr_t),
      .ldr_wdata_t(ldr_wdata_t), .ldr_rdata_t(ldr_rdata_t), .ldr_ack_t(ldr_ack_t),
      .ram_en_t(ram_en_t), .ram_we_t(ram_we_t), .ram_addr_t(ram_addr_t),
      .ram_wdata_t(ram_wdata_t), .ram_rdata_t(ram_rdata_t)
   );

   initial clk_t = 1'b0;
   always #5 clk_t = ~clk_t;

   // Synchronous RAM with a bench-side preload port.
   always @(posedge clk_t) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (ram_en_t && ram_we_t) mem[ram_addr_t] <= ram_wdata_t;
      if (ram_en_t && !ram_we_t) ram_rdata_t <= mem[ram_addr_t];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd0) return (addr % 4) != 0;
      if (size == 2'd2) return 1'b0;
      return (addr % 2) != 0;
   endfunction

   function automatic int exp_lat(input logic we, input logic [1:0] size, input logic [31:0] addr);
      if (ref_mis(size, addr)) return 1;
      if (!we) return 3;
      if (size == 2'd0) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
      logic [31:0] w, v;
      int unsigned sh;
      w = ref_mem[(addr / 4) % 1024];
      if (size == 2'd0) return w;
      if (size == 2'd2) begin
         sh = (addr % 4) * 8;
         v = (w >> sh) & 32'hFF;
         if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else begin
         sh = ((addr / 2) % 2) * 16;
         v = (w >> sh) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
      int idx;
      int unsigned sh;
      logic [31:0] w, m;
      idx = int'((addr / 4) % 1024);
      w = ref_mem[idx];
      if (size == 2'd0) begin
         w = wd;
      end else begin
         if (size == 2'd2) begin
            sh = (addr % 4) * 8;
            m = 32'hFF;
         end else begin
            sh = ((addr / 2) % 2) * 16;
            m = 32'hFFFF;
         end
         w = (w & ~(m << sh)) | ((wd & m) << sh);
      end
      ref_mem[idx] = w;
   endtask

   task automatic poke(input int idx, input logic [31:0] d);
      poke_en = 1'b1;
      poke_addr = idx[AW-1:0];
      poke_data = d;
      ref_mem[idx] = d;
      @(posedge clk_t); #1;
      poke_en = 1'b0;
   endtask

   task automatic do_reset();
      core_req_t = 1'b0;
      ldr_req_t = 1'b0;
      rst_t = 1'b1;
      @(posedge clk_t); #1;
      rst_t = 1'b0;
   endtask

   task automatic core_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int ack_cyc, output logic [31:0] rd, output logic mis,
                          output logic [15:0] en_log, output logic [15:0] we_log);
      core_we_t = we; core_size_t = size; core_unsigned_t = uns;
      core_addr_t = addr; core_wdata_t = wd; core_req_t = 1'b1;
      ack_cyc = -1; rd = 32'h0; mis = 1'b0; en_log = 16'h0; we_log = 16'h0;
      for (int k = 1; k <= 12 && ack_cyc < 0; k++) begin
         @(posedge clk_t); #1;
         en_log[k] = ram_en_t;
         we_log[k] = ram_we_t;
         if (core_ack_t) begin
            ack_cyc = k; rd = core_rdata_t; mis = core_misalign_t; core_req_t = 1'b0;
         end else begin
            core_addr_t = $urandom; core_wdata_t = $urandom;
            core_size_t = 2'($urandom); core_we_t = 1'($urandom); core_unsigned_t = 1'($urandom);
         end
      end
      core_req_t = 1'b0;
      @(posedge clk_t); #1;
   endtask

   task automatic ldr_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int ack_cyc, output logic [31:0] rd);
      ldr_we_t = we; ldr_addr_t = addr; ldr_wdata_t = wd; ldr_req_t = 1'b1;
      ack_cyc = -1; rd = 32'h0;
      for (int k = 1; k <= 12 && ack_cyc < 0; k++) begin
         @(posedge clk_t); #1;
         if (ldr_ack_t) begin
            ack_cyc = k; rd = ldr_rdata_t; ldr_req_t = 1'b0;
         end else begin
            ldr_addr_t = $urandom; ldr_wdata_t = $urandom; ldr_we_t = 1'($urandom);
         end
      end
      ldr_req_t = 1'b0;
      @(posedge clk_t); #1;
   endtask

   initial begin
      int          lat, n, n_ack;
      logic [31:0] rd, addr, wd, old_w;
      logic        mis, we, uns, use_ldr, bad;
      logic [1:0]  size;
      logic [15:0] en_log, we_log;
      int          ack_port [0:7];
      int          ack_at [0:7];
      logic [31:0] ack_rd [0:7];

      n_checks = 0; n_errors = 0;
      core_req_t = 1'b0; core_we_t = 1'b0; core_size_t = 2'd0; core_unsigned_t = 1'b0;
      core_addr_t = 32'h0; core_wdata_t = 32'h0;
      ldr_req_t = 1'b0; ldr_we_t = 1'b0; ldr_addr_t = 32'h0; ldr_wdata_t = 32'h0;
      poke_en = 1'b0; poke_addr = '0; poke_data = 32'h0;
      rst_t = 1'b1;
      @(posedge clk_t); #1;

      check_val("rst_ctrl", {27'h0, core_ack_t, core_misalign_t, ldr_ack_t, ram_en_t, ram_we_t}, 32'h0);
      check_val("rst_core_rdata", core_rdata_t, 32'h0);
      check_val("rst_ldr_rdata", ldr_rdata_t, 32'h0);
      check_val("rst_ram_addr", {22'h0, ram_addr_t}, 32'h0);
      check_val("rst_ram_wdata", ram_wdata_t, 32'h0);
      rst_t = 1'b0;

      for (int i = 0; i < 16; i++) poke(i, $urandom);

      // Byte store read-modify-write.
      poke(1, 32'h1122_3344);
      core_op(1'b1, 2'd2, 1'b0, 32'h6, 32'h0000_00AB, lat, rd, mis, en_log, we_log);
      check_val("sb_ack_cycle", 32'(lat), 32'd4);
      check_val("sb_strobes", {24'h0, en_log[4:1], we_log[4:1]}, {24'h0, 4'b0101, 4'b0100});
      check_val("sb_ram1", mem[1], 32'h11AB_3344);
      ref_mem[1] = 32'h11AB_3344;

      // Signed and unsigned byte load.
      poke(0, 32'h80FF_0000);
      core_op(1'b0, 2'd2, 1'b0, 32'h3, 32'h0, lat, rd, mis, en_log, we_log);
      check_val("lb_ack_cycle", 32'(lat), 32'd3);
      check_val("lb_data", rd, 32'hFFFF_FF80);
      core_op(1'b0, 2'd2, 1'b1, 32'h3, 32'h0, lat, rd, mis, en_log, we_log);
      check_val("lbu_ack_cycle", 32'(lat), 32'd3);
      check_val("lbu_data", rd, 32'h0000_0080);

      // Misaligned word load and halfword store.
      core_op(1'b0, 2'd0, 1'b0, 32'h2, 32'h0, lat, rd, mis, en_log, we_log);
      check_val("lw_mis_ack", 32'(lat), 32'd1);
      check_val("lw_mis_flag", {31'h0, mis}, 32'd1);
      check_val("lw_mis_rdata", rd, 32'h0);
      check_val("lw_mis_noen", {16'h0, en_log}, 32'h0);
      core_op(1'b1, 2'd1, 1'b0, 32'h5, 32'hCAFE_F00D, lat, rd, mis, en_log, we_log);
      check_val("sh_mis_ack", 32'(lat), 32'd1);
      check_val("sh_mis_flag", {31'h0, mis}, 32'd1);
      check_val("sh_mis_noen", {16'h0, en_log}, 32'h0);
      check_val("mis_ram0", mem[0], ref_mem[0]);
      check_val("mis_ram1", mem[1], ref_mem[1]);

      // Loader address wraps modulo RAM size.
      ldr_op(1'b1, 32'h1000, 32'h5A5A_1234, lat, rd);
      check_val("wrap_ack_cycle", 32'(lat), 32'd2);
      check_val("wrap_ram0", mem[0], 32'h5A5A_1234);
      ref_mem[0] = 32'h5A5A_1234;
      ldr_op(1'b0, 32'h1003, 32'h0, lat, rd);
      check_val("ldr_rd_ack_cycle", 32'(lat), 32'd3);
      check_val("ldr_rd_data", rd, 32'h5A5A_1234);

      // Reset during RD_DATA of a byte store drops it.
      poke(2, 32'h0BAD_F00D);
      core_we_t = 1'b1; core_size_t = 2'd2; core_unsigned_t = 1'b0;
      core_addr_t = 32'h9; core_wdata_t = 32'h0000_0077; core_req_t = 1'b1;
      @(posedge clk_t); #1;
      @(posedge clk_t); #1;
      rst_t = 1'b1; core_req_t = 1'b0;
      @(posedge clk_t); #1;
      rst_t = 1'b0;
      check_val("midrst_ctrl", {27'h0, core_ack_t, core_misalign_t, ldr_ack_t, ram_en_t, ram_we_t}, 32'h0);
      check_val("midrst_wdata", ram_wdata_t, 32'h0);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_t); #1;
         bad = bad | ram_en_t | core_ack_t | ldr_ack_t;
      end
      check_val("midrst_quiet", {31'h0, bad}, 32'h0);
      check_val("midrst_ram2", mem[2], 32'h0BAD_F00D);

      // Both ports requesting continuously: grants alternate, core first.
      do_reset();
      old_w = ref_mem[4];
      core_we_t = 1'b0; core_size_t = 2'd0; core_unsigned_t = 1'b0; core_addr_t = 32'h10;
      ldr_we_t = 1'b1; ldr_addr_t = 32'h10; ldr_wdata_t = 32'hDEAD_BEEF;
      core_req_t = 1'b1; ldr_req_t = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 8; i++) begin ack_port[i] = 0; ack_at[i] = 0; ack_rd[i] = 32'h0; end
      for (int k = 1; k <= 40 && n_ack < 4; k++) begin
         @(posedge clk_t); #1;
         if (core_ack_t && n_ack < 8) begin
            ack_port[n_ack] = 1; ack_at[n_ack] = k; ack_rd[n_ack] = core_rdata_t; n_ack++;
         end
         if (ldr_ack_t && n_ack < 8) begin
            ack_port[n_ack] = 2; ack_at[n_ack] = k; n_ack++;
         end
      end
      core_req_t = 1'b0; ldr_req_t = 1'b0;
      @(posedge clk_t); #1;
      check_val("arb_order", {ack_port[0][7:0], ack_port[1][7:0], ack_port[2][7:0], ack_port[3][7:0]}, 32'h0102_0102);
      check_val("arb_cycles", {ack_at[0][7:0], ack_at[1][7:0], ack_at[2][7:0], ack_at[3][7:0]}, {8'd3, 8'd6, 8'd10, 8'd13});
      check_val("arb_rd_first", ack_rd[0], old_w);
      check_val("arb_rd_second", ack_rd[2], 32'hDEAD_BEEF);
      check_val("arb_ram4", mem[4], 32'hDEAD_BEEF);
      ref_mem[4] = 32'hDEAD_BEEF;

      // Randomized single-port traffic against the reference memory.
      for (int t = 0; t < 80; t++) begin
         use_ldr = ($urandom_range(0, 3) == 0);
         we = 1'($urandom);
         addr = $urandom & 32'hFFFF_F03F;
         wd = $urandom;
         if (use_ldr) begin
            ldr_op(we, addr, wd, lat, rd);
            check_val("rnd_ldr_lat", 32'(lat), we ? 32'd2 : 32'd3);
            if (we) begin
               ref_store(2'd0, addr & 32'hFFFF_FFFC, wd);
               check_val("rnd_ldr_rd", rd, 32'h0);
            end else begin
               check_val("rnd_ldr_rd", rd, ref_mem[(addr / 4) % 1024]);
            end
         end else begin
            size = 2'($urandom);
            uns = 1'($urandom);
            core_op(we, size, uns, addr, wd, lat, rd, mis, en_log, we_log);
            check_val("rnd_core_lat", 32'(lat), 32'(exp_lat(we, size, addr)));
            check_val("rnd_core_mis", {31'h0, mis}, {31'h0, ref_mis(size, addr)});
            if (ref_mis(size, addr) || we) begin
               check_val("rnd_core_rd", rd, 32'h0);
               if (!ref_mis(size, addr)) ref_store(size, addr, wd);
            end else begin
               check_val("rnd_core_rd", rd, ref_load(size, uns, addr));
            end
         end
         n = $urandom_range(0, 2);
         repeat (n) begin @(posedge clk_t); #1; end
      end

      for (int i = 0; i < 16; i++) check_val("final_ram", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller for the single-cycle core's data RAM. It arbitrates the distributed data RAM between the core load/store port and a word-wide program/data loader port. It turns byte and halfword stores into read-modify-write sequences on the word-wide RAM, and extracts and extends sub-word loads. It sits between the core's `d_mem_*` control/ALU address path and the data RAM.

## Interface
- `ADDR_WIDTH`, default 10: RAM word-address width (1024 × 32-bit words).
- `clk_t` in 1: clock, rising edge.
- `rst_t` in 1: reset, synchronous, active-high.
- `core_req_t` in 1: core request; held until `core_ack_t`.
- `core_we_t` in 1: 1 = store, 0 = load.
- `core_size_t` in 2: 00 word, 01 half, 10 byte, 11 treated as half.
- `core_unsigned_t` in 1: load zero-extends (LBU/LHU) when 1, else sign-extends.
- `core_addr_t` in 32: byte address (ALU output).
- `core_wdata_t` in 32: store data; the low byte/half is used for sub-word stores.
- `core_rdata_t` out 32: load result, valid while `core_ack_t` is high.
- `core_ack_t` out 1: one-cycle completion pulse.
- `core_misalign_t` out 1: qualifies `core_ack_t`; access was misaligned and not performed.
- `ldr_req_t`, `ldr_we_t` in 1: loader request and write enable; word accesses only.
- `ldr_addr_t` in 32: byte address; bits [1:0] ignored.
- `ldr_wdata_t` in 32: loader write data.
- `ldr_rdata_t` out 32: loader read data.
- `ldr_ack_t` out 1: loader completion pulse.
- `ram_en_t`, `ram_we_t` out 1: RAM access strobe and write enable.
- `ram_addr_t` out ADDR_WIDTH: RAM word address.
- `ram_wdata_t` out 32: RAM write data.
- `ram_rdata_t` in 32: RAM read data, valid 1 cycle after a read strobe.

## Operation
- **States:** IDLE, RD, RD_DATA, WR, DONE.
- **IDLE:**
  - With no request, stay in IDLE.
  - Otherwise grant one port, then latch we/size/unsigned/addr/wdata and the grant.
  - Next state: misaligned → DONE with error flag; word store → WR; any load or sub-word store → RD.
- **RD:**
  - Drive `ram_en_t`=1, `ram_we_t`=0, `ram_addr_t`=latched addr[ADDR_WIDTH+1:2].
  - Go to RD_DATA.
- **RD_DATA:** sample `ram_rdata_t`.
  - Load: register the extracted lane. Byte lane = addr[1:0], half lane = addr[1]. Sign- or zero-extend to 32. Go to DONE.
  - Sub-word store: register the word with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to WR.
- **WR:**
  - Drive `ram_en_t`=1, `ram_we_t`=1, same address, `ram_wdata_t`= merged word (or latched wdata for a word store).
  - Go to DONE.
- **DONE:**
  - Pulse the granted port's ack. `*_rdata_t` holds the registered result (0 for stores and errors).
  - Go to IDLE.
- **Arbitration:** round-robin on conflict only; the port not granted last wins. After reset, the core wins the first conflict. A lone requester is always granted.
- **Misalignment:** half with addr[0]=1, or word with addr[1:0]≠0. No RAM strobe. Ack with `core_misalign_t`=1 and rdata 0. The loader is never misaligned.
- **Address range:** address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo RAM size.
- **RAM outputs:** `ram_en_t`/`ram_we_t` are 0 in IDLE, RD_DATA and DONE; the RAM is never written outside WR.

## Timing
- Request sampled in IDLE at cycle 0. Ack cycle:
  - load: cycle 3
  - word store: cycle 2
  - sub-word store: cycle 4
  - misaligned access: cycle 1
- Requester drops `req` in the cycle following ack. A request still high in IDLE is a new transaction.
- Request inputs are latched at grant; later changes are ignored until ack.
- **Reset:**
  - Every output is 0 and state is IDLE on the cycle after `rst_t` is sampled high.
  - Round-robin pointer is set to "last = loader".
  - Reset mid-transaction drops it: no ack, and no RAM write after reset is sampled.
- Both ports requesting in IDLE: exactly one is granted; the other waits a full transaction and is granted at the next IDLE.

## Structure
- Shared defines include (alongside the existing width defines):
  - size encodings `DMEM_WORD`/`DMEM_HALF`/`DMEM_BYTE`
  - FSM state encodings
  - `DATA_WIDTH`=32
- Sub-module `dmem_lane`: combinational.
  - Load extraction with sign/zero extend.
  - Store merge from (word, wdata, size, addr[1:0]).
- The FSM, latches and arbiter live in `dmem_ctrl`.

## Test plan
- **Byte store RMW:** RAM[1]=0x11223344; core SB addr 0x6, wdata 0xAB.
  - RAM read at cycle 1 and write 0x11AB3344 at cycle 3.
  - `core_ack_t` at cycle 4.
- **Signed vs unsigned byte load:** RAM[0]=0x80FF0000, addr 0x3.
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
  - Ack at cycle 3 in both cases.
- **Misaligned:** LW addr 0x2 and SH addr 0x5.
  - Ack at cycle 1 with `core_misalign_t`=1.
  - No `ram_en_t`; RAM unchanged.
- **Arbitration:** both ports request continuously.
  - Grants alternate core, loader, core…
  - Loader word write 0xDEADBEEF to addr 0x10 lands in RAM[4].
- **Wrap:** loader write to addr 0x1000 (ADDR_WIDTH=10) writes RAM[0].
- **Reset mid-op:** assert `rst_t` during the RD_DATA of an SB.
  - No WR strobe and no ack.
  - All outputs 0 on the next cycle.
  - RAM word unchanged.
